animated_sprite_draw: RTL and testbench
=======================================

// Module: animated_sprite_draw
// PURPOSE
//  Parametrised bitmap sprite renderer for projectiles and other moving objects. Converts the
//  pixel offset inside an object's bounding rectangle into an 8-bit RGB value and a drawing request.
//  Adds multi-frame animation, X/Y mirroring and power-of-two scaling through a 2-stage pipeline.
//  Sits between the object's square/rectangle locator and the VGA object mux.
// PARAMETERS
//  OBJ_X_BITS      5      log2 of bitmap width (WIDTH = 1<<OBJ_X_BITS)
//  OBJ_Y_BITS      5      log2 of bitmap height (HEIGHT = 1<<OBJ_Y_BITS)
//  FRAMES          4      number of animation frames, >=1
//  FRAME_PERIOD    8      startOfFrame pulses per animation step, >=1
//  TRANSPARENT     8'hFF  RGB code treated as transparent
// PORTS
//  clk             in   1    pixel clock
//  reset           in   1    synchronous, active-high reset
//  offsetX         in   11   X offset from the rectangle's top-left corner
//  offsetY         in   11   Y offset from the rectangle's top-left corner
//  InsideRectangle in   1    current pixel is inside the bounding rectangle
//  startOfFrame    in   1    1-cycle pulse, once per VGA frame
//  animEnable      in   1    animation advances only while high
//  loopMode        in   1    1 = wrap to frame 0 after the last frame, 0 = one-shot, hold last frame
//  animRestart     in   1    1-cycle pulse: frame index := 0, period count := 0
//  mirrorX         in   1    flip horizontally
//  mirrorY         in   1    flip vertically
//  scaleShift      in   2    scale = 1<<scaleShift (0..2 valid; 3 is treated as 2)
//  object_colors   in   FRAMES*HEIGHT*WIDTH*8  packed [frame][y][x][7:0] bitmap
//  drawingRequest  out  1    RGBout is not TRANSPARENT
//  RGBout          out  8    pixel colour
//  frameIdx        out  $clog2(FRAMES) max 1   current animation frame
//  animDone        out  1    1-cycle pulse when one-shot reaches the last frame
// BEHAVIOUR
//  Reset: RGBout=TRANSPARENT, drawingRequest=0, frameIdx=0, period count=0, animDone=0,
//    pipeline valid=0.
//  Pipeline, latency 2 clk from offsets/InsideRectangle to RGBout/drawingRequest.
//  Stage 1 (registered):
//    - sx = offsetX>>s, sy = offsetY>>s, where s = min(scaleShift,2)
//    - inRange = InsideRectangle && sx<WIDTH && sy<HEIGHT
//    - ix = mirrorX ? WIDTH-1-sx : sx
//    - iy = mirrorY ? HEIGHT-1-sy : sy
//    - frame index is sampled together with the coordinates
//  Stage 2 (registered):
//    - RGBout = inRange ? object_colors[f][iy][ix] : TRANSPARENT
//    - drawingRequest is registered in the same cycle: drawingRequest = (RGBout != TRANSPARENT)
//  Animation, evaluated only on startOfFrame, so the frame never changes mid-frame:
//    - If animEnable: period count increments. When it reaches FRAME_PERIOD-1 it clears and
//      frame advances.
//    - Advance at the last frame: loopMode=1 -> frame 0. loopMode=0 -> hold the frame and
//      stop counting.
//    - animDone pulses for 1 clk on the step that reaches FRAMES-1 in one-shot mode only.
//  animRestart has priority over a simultaneous startOfFrame step: frame 0, count 0, no animDone.
//  animEnable low freezes the frame index and the period count; no other state changes.
//  FRAMES=1: frameIdx stays 0. animDone pulses on the first step in one-shot mode.
//  Reset mid-pipeline flushes both stages: RGBout is TRANSPARENT on the next cycle.
//  Offsets of 11 bits are never truncated before the range check, so large offsets are transparent.
// STRUCTURE
//  Shared package sprite_pkg:
//    - TRANSPARENT_ENCODING constant
//    - rgb_t (logic [7:0])
//    - scale_t (logic [1:0])
//  One sub-module: sprite_anim_ctrl holds the period counter, frame index, loop/one-shot logic
//    and animDone. The top holds the 2-stage pixel pipeline.
// TESTING
//  1. Reset, then InsideRectangle=1, offset (3,2), frame 0 pixel = 8'h1C
//     -> RGBout=8'h1C, drawingRequest=1, exactly 2 clk later.
//  2. mirrorX=1, offset (0,0), WIDTH=32 -> RGBout = frame0[0][31].
//     mirrorY=1 as well -> frame0[31][31].
//  3. scaleShift=1, offsets (0..63, 5) -> each source pixel repeated twice.
//     Offset X=64 -> TRANSPARENT, drawingRequest=0.
//  4. loopMode=1, FRAME_PERIOD=8, animEnable=1, 40 startOfFrame pulses
//     -> frameIdx sequence 0,1,2,3,0,... Steps on pulses 8,16,24,32,40.
//  5. loopMode=0 -> frameIdx reaches 3 on pulse 24 with one animDone pulse, then holds 3.
//     animRestart together with startOfFrame -> frameIdx=0, no animDone.
//  6. Pixel of value 8'hFF inside the rectangle -> drawingRequest=0.
//     Assert reset mid-stream -> next cycle RGBout=8'hFF, frameIdx=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the animated sprite renderer.
// Imported by the interface, the animation controller and the top.
package sprite_pkg;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    typedef logic [7:0] rgb_t;
    typedef logic [1:0] scale_t;

    // Scale codes above 2 saturate to the largest supported scale.
    function automatic logic [1:0] eff_shift(scale_t s);
        return (s == 2'd3) ? 2'd2 : s;
    endfunction

endpackage

// File: rtl/animated_sprite_draw_if.sv
// Pixel/animation bus between the rectangle locator, the sprite
// renderer and the VGA object mux.
interface animated_sprite_draw_if
    import sprite_pkg::*;
#(
    parameter int FW = 2
) ();

    logic [10:0]   offsetX;
    logic [10:0]   offsetY;
    logic          InsideRectangle;
    logic          startOfFrame;
    logic          animEnable;
    logic          loopMode;
    logic          animRestart;
    logic          mirrorX;
    logic          mirrorY;
    scale_t        scaleShift;
    logic          drawingRequest;
    rgb_t          RGBout;
    logic [FW-1:0] frameIdx;
    logic          animDone;

    modport master (
        output offsetX, offsetY, InsideRectangle,
        output startOfFrame, animEnable, loopMode,
        output animRestart, mirrorX, mirrorY, scaleShift,
        input  drawingRequest, RGBout, frameIdx, animDone
    );

    modport slave (
        input  offsetX, offsetY, InsideRectangle,
        input  startOfFrame, animEnable, loopMode,
        input  animRestart, mirrorX, mirrorY, scaleShift,
        output drawingRequest, RGBout, frameIdx, animDone
    );

endinterface

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: period counter, frame index, loop/one-shot
// handling and the one-shot completion pulse.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int FRAMES       = 4,
    parameter int FRAME_PERIOD = 8,
    parameter int FW           = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_of_frame,
    input  logic          anim_enable,
    input  logic          loop_mode,
    input  logic          anim_restart,
    output logic [FW-1:0] frame_idx,
    output logic          anim_done
);

    localparam int CW =
        (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [FW-1:0] LAST = FW'(FRAMES - 1);
    localparam logic [CW-1:0] CMAX = CW'(FRAME_PERIOD - 1);
    localparam logic ONE_FRAME = (FRAMES == 1);

    logic [CW-1:0] count_q, count_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          stopped_q, stopped_d;
    logic          done_q, done_d;
    logic          hold;

    // Next-state: restart wins, otherwise step once per enabled frame pulse.
    always_comb begin
        count_d   = count_q;
        frame_d   = frame_q;
        stopped_d = stopped_q;
        done_d    = 1'b0;
        hold      = stopped_q && !loop_mode;
        if (anim_restart) begin
            count_d   = '0;
            frame_d   = '0;
            stopped_d = 1'b0;
        end else if (start_of_frame && anim_enable && !hold) begin
            if (count_q != CMAX) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = '0;
                if (frame_q == LAST) begin
                    if (loop_mode) begin
                        frame_d   = '0;
                        stopped_d = 1'b0;
                    end else begin
                        stopped_d = 1'b1;
                        done_d    = ONE_FRAME;
                    end
                end else begin
                    frame_d = frame_q + 1'b1;
                    done_d  = !loop_mode && (frame_d == LAST);
                end
            end
        end
    end

    // Animation state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            frame_q   <= '0;
            stopped_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            frame_q   <= frame_d;
            stopped_q <= stopped_d;
            done_q    <= done_d;
        end
    end

    assign frame_idx = frame_q;
    assign anim_done = done_q;

endmodule

// File: rtl/animated_sprite_draw.sv
// Animated bitmap sprite renderer: scale, mirror and look up a pixel
// through a 2-stage pipeline; animation is sequenced by sprite_anim_ctrl.
module animated_sprite_draw
    import sprite_pkg::*;
#(
    parameter int   OBJ_X_BITS   = 5,
    parameter int   OBJ_Y_BITS   = 5,
    parameter int   FRAMES       = 4,
    parameter int   FRAME_PERIOD = 8,
    parameter rgb_t TRANSPARENT  = TRANSPARENT_ENCODING,
    localparam int  WIDTH        = 1 << OBJ_X_BITS,
    localparam int  HEIGHT       = 1 << OBJ_Y_BITS,
    localparam int  FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input logic clk,
    input logic reset,
    animated_sprite_draw_if.slave bus,
    input logic [FRAMES-1:0][HEIGHT-1:0][WIDTH-1:0][7:0]
        object_colors
);

    logic [1:0]            shift;
    logic [10:0]           sx;
    logic [10:0]           sy;
    logic                  in_range;
    logic [OBJ_X_BITS-1:0] ix;
    logic [OBJ_Y_BITS-1:0] iy;

    logic                  s1_valid;
    logic [OBJ_X_BITS-1:0] s1_ix;
    logic [OBJ_Y_BITS-1:0] s1_iy;
    logic [FW-1:0]         s1_frame;

    rgb_t                  pix;
    rgb_t                  rgb_q;
    logic                  req_q;
    logic [FW-1:0]         frame_idx;

    sprite_anim_ctrl #(
        .FRAMES       (FRAMES),
        .FRAME_PERIOD (FRAME_PERIOD),
        .FW           (FW)
    ) u_anim (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (bus.startOfFrame),
        .anim_enable    (bus.animEnable),
        .loop_mode      (bus.loopMode),
        .anim_restart   (bus.animRestart),
        .frame_idx      (frame_idx),
        .anim_done      (bus.animDone)
    );

    // Scale down the full 11-bit offsets, range check, then mirror.
    always_comb begin
        shift    = eff_shift(bus.scaleShift);
        sx       = bus.offsetX >> shift;
        sy       = bus.offsetY >> shift;
        in_range = bus.InsideRectangle
                   && (sx < 11'(WIDTH))
                   && (sy < 11'(HEIGHT));
        ix = bus.mirrorX ? ~sx[OBJ_X_BITS-1:0]
                         : sx[OBJ_X_BITS-1:0];
        iy = bus.mirrorY ? ~sy[OBJ_Y_BITS-1:0]
                         : sy[OBJ_Y_BITS-1:0];
    end

    // Stage 1: bitmap coordinates and the frame they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ix    <= '0;
            s1_iy    <= '0;
            s1_frame <= '0;
        end else begin
            s1_valid <= in_range;
            s1_ix    <= ix;
            s1_iy    <= iy;
            s1_frame <= frame_idx;
        end
    end

    // Bitmap lookup; out-of-range pixels are transparent.
    always_comb begin
        pix = TRANSPARENT;
        if (s1_valid) begin
            pix = object_colors[s1_frame][s1_iy][s1_ix];
        end
    end

    // Stage 2: colour and its drawing request, registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= TRANSPARENT;
            req_q <= 1'b0;
        end else begin
            rgb_q <= pix;
            req_q <= (pix != TRANSPARENT);
        end
    end

    assign bus.RGBout         = rgb_q;
    assign bus.drawingRequest = req_q;
    assign bus.frameIdx       = frame_idx;

endmodule

// File: tb/tb_animated_sprite_draw.sv
// Directed bench for animated_sprite_draw: pipeline latency, mirroring,
// scaling, range limits, loop/one-shot animation, restart and reset.
module tb_animated_sprite_draw;

    logic clk = 1'b0;
    logic reset;
    logic [3:0][31:0][31:0][7:0] colors;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    animated_sprite_draw_if #(.FW(2)) bus ();

    animated_sprite_draw dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .object_colors (colors)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel, wait out the 2-cycle latency, check colour/request.
    task automatic probe(input string tag,
                         input int x, input int y,
                         input logic [7:0] exp);
        bus.offsetX = 11'(x);
        bus.offsetY = 11'(y);
        bus.InsideRectangle = 1'b1;
        tick();
        tick();
        check({tag, " rgb"}, 32'(bus.RGBout), 32'(exp));
        check({tag, " req"}, 32'(bus.drawingRequest),
              32'(exp != 8'hFF));
    endtask

    task automatic sof(output logic done);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        done = bus.animDone;
    endtask

    task automatic restart();
        bus.animRestart = 1'b1;
        tick();
        bus.animRestart = 1'b0;
    endtask

    initial begin
        logic d;
        int   e;

        for (int f = 0; f < 4; f++)
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 32; x++)
                    colors[f][y][x] = 8'((x*7 + y*13 + f*61) & 8'h7F);
        colors[0][2][3] = 8'h1C;
        colors[0][4][4] = 8'hFF;

        reset = 1'b1;
        bus.offsetX = '0;
        bus.offsetY = '0;
        bus.InsideRectangle = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.animEnable = 1'b0;
        bus.loopMode = 1'b1;
        bus.animRestart = 1'b0;
        bus.mirrorX = 1'b0;
        bus.mirrorY = 1'b0;
        bus.scaleShift = 2'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst rgb", 32'(bus.RGBout), 32'hFF);
        check("rst req", 32'(bus.drawingRequest), 0);
        check("rst frame", 32'(bus.frameIdx), 0);
        check("rst done", 32'(bus.animDone), 0);

        // Latency: nothing after 1 clk, pixel after exactly 2.
        bus.offsetX = 11'd3;
        bus.offsetY = 11'd2;
        bus.InsideRectangle = 1'b1;
        tick();
        check("lat1 rgb", 32'(bus.RGBout), 32'hFF);
        tick();
        check("lat2 rgb", 32'(bus.RGBout), 32'h1C);
        check("lat2 req", 32'(bus.drawingRequest), 1);

        probe("outside", 3, 2, colors[0][2][3]);
        bus.InsideRectangle = 1'b0;
        tick();
        tick();
        check("noinside", 32'(bus.RGBout), 32'hFF);

        bus.mirrorX = 1'b1;
        probe("mx 0,0", 0, 0, colors[0][0][31]);
        probe("mx 31,0", 31, 0, colors[0][0][0]);
        bus.mirrorY = 1'b1;
        probe("mxy 0,0", 0, 0, colors[0][31][31]);
        probe("mxy 5,9", 5, 9, colors[0][22][26]);
        bus.mirrorX = 1'b0;
        bus.mirrorY = 1'b0;

        bus.scaleShift = 2'd1;
        for (int x = 0; x < 64; x++)
            probe("scale1", x, 5, colors[0][2][x/2]);
        probe("scale1 x64", 64, 5, 8'hFF);
        bus.scaleShift = 2'd3;
        probe("scale3", 100, 20, colors[0][5][25]);
        probe("scale3 x128", 128, 0, 8'hFF);
        bus.scaleShift = 2'd0;
        probe("big off", 2047, 0, 8'hFF);
        probe("x32", 32, 0, 8'hFF);
        probe("y32", 0, 32, 8'hFF);
        probe("transp", 4, 4, 8'hFF);
        bus.InsideRectangle = 1'b0;

        // Looping animation.
        bus.animEnable = 1'b1;
        bus.loopMode = 1'b1;
        restart();
        for (int p = 1; p <= 40; p++) begin
            sof(d);
            e = (p / 8) % 4;
            check($sformatf("loop p%0d frame", p),
                  32'(bus.frameIdx), 32'(e));
            check($sformatf("loop p%0d done", p), 32'(d), 0);
        end

        // One-shot animation.
        bus.loopMode = 1'b0;
        restart();
        check("restart frame", 32'(bus.frameIdx), 0);
        for (int p = 1; p <= 40; p++) begin
            sof(d);
            e = (p / 8 > 3) ? 3 : p / 8;
            check($sformatf("shot p%0d frame", p),
                  32'(bus.frameIdx), 32'(e));
            check($sformatf("shot p%0d done", p),
                  32'(d), 32'(p == 24));
        end
        bus.startOfFrame = 1'b1;
        bus.animRestart = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        bus.animRestart = 1'b0;
        check("rst+sof frame", 32'(bus.frameIdx), 0);
        check("rst+sof done", 32'(bus.animDone), 0);

        // Enable low freezes the partial period count.
        bus.loopMode = 1'b1;
        for (int p = 0; p < 7; p++) sof(d);
        check("pre-freeze", 32'(bus.frameIdx), 0);
        bus.animEnable = 1'b0;
        for (int p = 0; p < 10; p++) sof(d);
        check("frozen", 32'(bus.frameIdx), 0);
        bus.animEnable = 1'b1;
        sof(d);
        check("unfreeze", 32'(bus.frameIdx), 1);

        // Frame index travels with the coordinates.
        probe("frame1 px", 1, 1, colors[1][1][1]);

        // Reset in the middle of a pixel stream.
        bus.offsetX = 11'd6;
        bus.offsetY = 11'd3;
        bus.InsideRectangle = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("midrst rgb", 32'(bus.RGBout), 32'hFF);
        check("midrst req", 32'(bus.drawingRequest), 0);
        check("midrst frame", 32'(bus.frameIdx), 0);
        reset = 1'b0;
        tick();
        check("postrst rgb", 32'(bus.RGBout), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
